// File: rtl/maze_pkg.sv
// maze_pkg: heading codes, FSM states and rotation selects shared by the maze solver
package maze_pkg;
  localparam logic [11:0] HDG_N = 12'h000;
  localparam logic [11:0] HDG_W = 12'h3FF;
  localparam logic [11:0] HDG_S = 12'h7FF;
  localparam logic [11:0] HDG_E = 12'hC00;
  typedef enum logic [2:0] {IDLE, MV_STRT, MV_WAIT, SETTLE, HD_STRT, HD_WAIT, DONE} state_t;
  typedef enum logic [1:0] {ROT_L, ROT_R, ROT_U} rot_t;
endpackage

// File: rtl/hdng_rot.sv
// hdng_rot: rotates a compass heading code left, right or by 180 degrees
module hdng_rot
  import maze_pkg::*;
(
  input  logic [11:0] hdng,
  input  rot_t        rot,
  output logic [11:0] new_hdng
);
  always_comb begin
    new_hdng = HDG_N;
    case (hdng)
      HDG_N: new_hdng = rot == ROT_L ? HDG_W : rot == ROT_R ? HDG_E : HDG_S;
      HDG_W: new_hdng = rot == ROT_L ? HDG_S : rot == ROT_R ? HDG_N : HDG_E;
      HDG_S: new_hdng = rot == ROT_L ? HDG_E : rot == ROT_R ? HDG_W : HDG_N;
      HDG_E: new_hdng = rot == ROT_L ? HDG_N : rot == ROT_R ? HDG_S : HDG_W;
      default: new_hdng = HDG_N;
    endcase
  end
endmodule

// File: rtl/maze_solve.sv
// maze_solve: wall-follow maze sequencer issuing move/heading strobes to navigation
module maze_solve
  import maze_pkg::*;
#(
  parameter int SETTLE_CYC = 1024,
  parameter bit FAST_SIM   = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_md,
  input  logic        cmd0,
  input  logic        mv_cmplt,
  input  logic        lft_opn,
  input  logic        rght_opn,
  input  logic        sol_cmplt,
  output logic        strt_mv,
  output logic        strt_hdng,
  output logic        stp_lft,
  output logic        stp_rght,
  output logic [11:0] dsrd_hdng,
  output logic        solving,
  output logic [7:0]  turn_cnt
);
  localparam int SETTLE_N = FAST_SIM ? 16 : SETTLE_CYC;
  localparam logic [15:0] LAST = 16'(SETTLE_N - 1);
  state_t state;
  logic aff;
  logic [15:0] cnt;
  rot_t rot;
  logic [11:0] new_hdng;
  logic aff_opn, oth_opn;
  // prefer the affinity wall, then the opposite opening, else turn around
  always_comb begin
    aff_opn = aff ? lft_opn : rght_opn;
    oth_opn = aff ? rght_opn : lft_opn;
    rot = aff_opn ? (aff ? ROT_L : ROT_R) : oth_opn ? (aff ? ROT_R : ROT_L) : ROT_U;
  end
  hdng_rot u_rot (.hdng(dsrd_hdng), .rot(rot), .new_hdng(new_hdng));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      aff       <= 1'b0;
      cnt       <= 16'd0;
      strt_mv   <= 1'b0;
      strt_hdng <= 1'b0;
      stp_lft   <= 1'b0;
      stp_rght  <= 1'b0;
      dsrd_hdng <= HDG_N;
      solving   <= 1'b0;
      turn_cnt  <= 8'd0;
    end else begin
      strt_mv   <= 1'b0;
      strt_hdng <= 1'b0;
      if (!cmd_md) begin
        state    <= IDLE;
        stp_lft  <= 1'b0;
        stp_rght <= 1'b0;
        solving  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            aff      <= cmd0;
            turn_cnt <= 8'd0;
            stp_lft  <= cmd0;
            stp_rght <= ~cmd0;
            strt_mv  <= 1'b1;
            solving  <= 1'b1;
            state    <= MV_STRT;
          end
          MV_STRT: state <= MV_WAIT;
          MV_WAIT: if (mv_cmplt) begin
            cnt     <= 16'd0;
            solving <= ~sol_cmplt;
            state   <= sol_cmplt ? DONE : SETTLE;
          end
          SETTLE: if (cnt == LAST) begin
            dsrd_hdng <= new_hdng;
            strt_hdng <= 1'b1;
            turn_cnt  <= turn_cnt + {7'd0, turn_cnt != 8'hFF};
            state     <= HD_STRT;
          end else cnt <= cnt + 16'd1;
          HD_STRT: state <= HD_WAIT;
          HD_WAIT: if (mv_cmplt) begin
            strt_mv <= 1'b1;
            state   <= MV_STRT;
          end
          DONE: state <= DONE;
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_maze_solve.sv
// tb_maze_solve: directed self-checking bench for the maze solver sequencer
module tb_maze_solve;
  logic clk = 1'b0, rst_n = 1'b1, cmd_md = 1'b0, cmd0 = 1'b0, mv_cmplt = 1'b0;
  logic lft_opn = 1'b0, rght_opn = 1'b0, sol_cmplt = 1'b0;
  logic strt_mv, strt_hdng, stp_lft, stp_rght, solving;
  logic [11:0] dsrd_hdng;
  logic [7:0] turn_cnt;
  int checks = 0, errors = 0;
  int lat, s;
  logic sm;
  always #5 clk = ~clk;
  maze_solve dut (
    .clk(clk), .rst_n(rst_n), .cmd_md(cmd_md), .cmd0(cmd0), .mv_cmplt(mv_cmplt),
    .lft_opn(lft_opn), .rght_opn(rght_opn), .sol_cmplt(sol_cmplt),
    .strt_mv(strt_mv), .strt_hdng(strt_hdng), .stp_lft(stp_lft), .stp_rght(stp_rght),
    .dsrd_hdng(dsrd_hdng), .solving(solving), .turn_cnt(turn_cnt)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(negedge clk);
  endtask
  // from MV_WAIT: complete a move, wait for the heading strobe, end in HD_WAIT
  task automatic to_hd_wait(input logic l, input logic r, input logic stray, output int n);
    lft_opn = l;
    rght_opn = r;
    sol_cmplt = 1'b0;
    mv_cmplt = 1'b1;
    step;
    n = 0;
    while (!strt_hdng && n < 40) begin
      mv_cmplt = stray && n == 5;
      step;
      n++;
    end
    mv_cmplt = 1'b0;
    step;
  endtask
  task automatic finish_move(output logic got_mv);
    mv_cmplt = 1'b1;
    step;
    got_mv = strt_mv;
    mv_cmplt = 1'b0;
    step;
  endtask
  task automatic count_strobes(input int n, output int cnt);
    cnt = 0;
    repeat (n) begin
      step;
      cnt += int'(strt_mv | strt_hdng);
    end
  endtask
  initial begin
    #2 rst_n = 1'b0;
    step;
    chk("rst_strt_mv", strt_mv, 0);
    chk("rst_strt_hdng", strt_hdng, 0);
    chk("rst_stp_lft", stp_lft, 0);
    chk("rst_stp_rght", stp_rght, 0);
    chk("rst_hdng", dsrd_hdng, 12'h000);
    chk("rst_solving", solving, 0);
    chk("rst_turn_cnt", turn_cnt, 0);
    rst_n = 1'b1;
    step;
    cmd0 = 1'b1;
    cmd_md = 1'b1;
    step;
    chk("a_strt_mv", strt_mv, 1);
    chk("a_stp_lft", stp_lft, 1);
    chk("a_stp_rght", stp_rght, 0);
    chk("a_hdng", dsrd_hdng, 12'h000);
    chk("a_solving", solving, 1);
    chk("a_no_hdng", strt_hdng, 0);
    step;
    chk("a_mv_pulse", strt_mv, 0);
    to_hd_wait(1'b1, 1'b1, 1'b0, lat);
    chk("a1_lat", lat, 16);
    chk("a1_hdng", dsrd_hdng, 12'h3FF);
    chk("a1_turn_cnt", turn_cnt, 1);
    chk("a1_hdng_pulse", strt_hdng, 0);
    finish_move(sm);
    chk("a1_strt_mv", sm, 1);
    sol_cmplt = 1'b1;
    mv_cmplt = 1'b1;
    step;
    mv_cmplt = 1'b0;
    sol_cmplt = 1'b0;
    chk("done_solving", solving, 0);
    count_strobes(20, s);
    chk("done_strobes", s, 0);
    chk("done_hdng", dsrd_hdng, 12'h3FF);
    chk("done_stp_lft", stp_lft, 1);
    cmd_md = 1'b0;
    step;
    chk("idle_stp_lft", stp_lft, 0);
    chk("idle_stp_rght", stp_rght, 0);
    chk("idle_solving", solving, 0);
    cmd0 = 1'b0;
    cmd_md = 1'b1;
    step;
    chk("b_strt_mv", strt_mv, 1);
    chk("b_stp_rght", stp_rght, 1);
    chk("b_stp_lft", stp_lft, 0);
    chk("b_turn_clr", turn_cnt, 0);
    step;
    to_hd_wait(1'b1, 1'b0, 1'b0, lat);
    chk("b1_hdng", dsrd_hdng, 12'h7FF);
    finish_move(sm);
    to_hd_wait(1'b0, 1'b0, 1'b1, lat);
    chk("b2_stray_lat", lat, 16);
    chk("b2_hdng", dsrd_hdng, 12'h000);
    finish_move(sm);
    chk("b2_strt_mv", sm, 1);
    to_hd_wait(1'b1, 1'b1, 1'b0, lat);
    chk("b3_hdng", dsrd_hdng, 12'hC00);
    finish_move(sm);
    to_hd_wait(1'b0, 1'b0, 1'b0, lat);
    chk("b4_hdng", dsrd_hdng, 12'h3FF);
    chk("b4_turn_cnt", turn_cnt, 4);
    finish_move(sm);
    lft_opn = 1'b1;
    rght_opn = 1'b1;
    mv_cmplt = 1'b1;
    step;
    mv_cmplt = 1'b0;
    repeat (6) step;
    cmd_md = 1'b0;
    step;
    chk("abs_solving", solving, 0);
    chk("abs_strt_hdng", strt_hdng, 0);
    chk("abs_stp_rght", stp_rght, 0);
    count_strobes(25, s);
    chk("abs_strobes", s, 0);
    chk("abs_hdng", dsrd_hdng, 12'h3FF);
    cmd_md = 1'b1;
    step;
    chk("c_strt_mv", strt_mv, 1);
    step;
    to_hd_wait(1'b0, 1'b0, 1'b0, lat);
    chk("c_hdng", dsrd_hdng, 12'hC00);
    cmd_md = 1'b0;
    mv_cmplt = 1'b1;
    step;
    mv_cmplt = 1'b0;
    chk("abh_strt_mv", strt_mv, 0);
    chk("abh_solving", solving, 0);
    chk("abh_hdng", dsrd_hdng, 12'hC00);
    count_strobes(5, s);
    chk("abh_strobes", s, 0);
    cmd0 = 1'b1;
    cmd_md = 1'b1;
    step;
    step;
    chk("sat_clr", turn_cnt, 0);
    for (int i = 0; i < 300; i++) begin
      to_hd_wait(1'b1, 1'b1, 1'b0, lat);
      chk("sat_lat", lat, 16);
      if (i == 253) chk("sat_fe", turn_cnt, 8'hFE);
      finish_move(sm);
    end
    chk("sat_ff", turn_cnt, 8'hFF);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/maze_solve.md
Name: maze_solve

Overview:
- Command-side sequencer for the navigation core: issues strt_mv/strt_hdng and stop-at-opening requests, then consumes mv_cmplt, the IR opening flags and sol_cmplt.
- Implements a wall-follow (left- or right-affinity) maze-solving policy.
- Sits between the command/UART layer (cmd_md, cmd0) and the navigation and PID blocks. dsrd_hdng goes to the PID; start/stop strobes go to navigation.

Parameters:
SETTLE_CYC, 1024, clocks to wait after a forward move completes before sampling lft_opn/rght_opn (IR settle time); legal range 1..65535
FAST_SIM, 1, when 1 the settle count is forced to 16 clocks for simulation

Ports:
clk  input  1  system clock, 50MHz
rst_n  input  1  reset, asynchronous, active-low
cmd_md  input  1  solve enable; high starts/continues solving, low aborts to IDLE
cmd0  input  1  affinity select, latched at start; 1 = left affinity, 0 = right affinity
mv_cmplt  input  1  one-clock pulse from navigation: heading or forward move finished
lft_opn  input  1  IR left opening present
rght_opn  input  1  IR right opening present
sol_cmplt  input  1  magnet/goal sensor; maze solved
strt_mv  output  1  one-clock pulse: start forward move
strt_hdng  output  1  one-clock pulse: start heading change to dsrd_hdng
stp_lft  output  1  navigation stops at first left opening rise
stp_rght  output  1  navigation stops at first right opening rise
dsrd_hdng  output  12  desired heading to PID
solving  output  1  high in every state except IDLE and DONE
turn_cnt  output  8  heading commands issued this run, saturating

Behaviour:
- All outputs are registered. Reset values: strt_mv=0, strt_hdng=0, stp_lft=0, stp_rght=0, dsrd_hdng=12'h000, solving=0, turn_cnt=0; state=IDLE.
- Heading codes: N=12'h000, W=12'h3FF, S=12'h7FF, E=12'hC00. dsrd_hdng only ever holds one of these four.
- Left rotation: N->W->S->E->N. Right rotation is the inverse. U-turn: N<->S, W<->E.
- An unmapped value of the heading register rotates to N. This is defensive only and cannot be reached.
- States: IDLE, MV_STRT, MV_WAIT, SETTLE, HD_STRT, HD_WAIT, DONE.
- IDLE:
  - stp_lft=stp_rght=0.
  - When cmd_md=1, latch aff=cmd0, clear turn_cnt and go to MV_STRT. The first action of a run is a forward move on the current dsrd_hdng.
- MV_STRT:
  - strt_mv=1 for exactly this one cycle.
  - stp_lft=aff and stp_rght=~aff, held until IDLE.
  - Go to MV_WAIT.
- MV_WAIT:
  - On mv_cmplt with sol_cmplt=1, go to DONE.
  - On mv_cmplt with sol_cmplt=0, load the settle counter and go to SETTLE.
- SETTLE:
  - Count 0..N-1, where N=SETTLE_CYC, or 16 when FAST_SIM=1.
  - At terminal count, decide the turn from that cycle's lft_opn/rght_opn:
    - Affinity side open: rotate toward the affinity side.
    - Else, the other side open: rotate toward the other side.
    - Else: U-turn.
  - Load dsrd_hdng on the same edge that enters HD_STRT.
- HD_STRT:
  - strt_hdng=1 for one cycle; dsrd_hdng is already stable.
  - turn_cnt increments, saturating at 8'hFF.
  - Go to HD_WAIT.
- HD_WAIT: on mv_cmplt, go to MV_STRT.
- DONE: solving=0 and outputs hold. Leave only when cmd_md=0, which returns to IDLE.
- cmd_md=0 in any state: IDLE on the next edge, no strobe issued, dsrd_hdng retained.
  - This abort has priority over mv_cmplt in the same cycle.
- mv_cmplt outside MV_WAIT/HD_WAIT is ignored.
- sol_cmplt is sampled only on the mv_cmplt cycle in MV_WAIT.
- Strobe latency:
  - cmd_md rise -> strt_mv high 1 clock later.
  - mv_cmplt in HD_WAIT -> strt_mv 1 clock later.
  - Settle terminal -> strt_hdng 1 clock later.
- strt_mv and strt_hdng are never high together, and never high for two consecutive cycles.

Decomposition:
- Shared package maze_pkg holds:
  - the heading code localparams HDG_N/W/S/E;
  - the state enum type;
  - the rotation-select enum (ROT_L, ROT_R, ROT_U).
- One combinational sub-module, hdng_rot: inputs are the current heading and the rotation select; output is the new heading.
- The counter and FSM stay in maze_solve.

Test Plan:
- Reset, then cmd_md=1, cmd0=1 -> strt_mv pulses 1 clk later; stp_lft=1, stp_rght=0; dsrd_hdng=000; solving=1.
- Left affinity, heading N, mv_cmplt with lft_opn=1, rght_opn=1 -> after 16 clks (FAST_SIM) dsrd_hdng=3FF, strt_hdng pulses, turn_cnt=1; mv_cmplt -> strt_mv.
- Right affinity, heading N, rght_opn=0, lft_opn=1 -> dsrd_hdng=3FF. Repeat with both closed -> 7FF; from 7FF with both closed -> 000.
- mv_cmplt with sol_cmplt=1 in MV_WAIT -> DONE, no strt_hdng, solving=0; cmd_md low -> IDLE, stp_lft=stp_rght=0.
- cmd_md dropped mid-SETTLE, and again on the same cycle as mv_cmplt in HD_WAIT -> IDLE next clk, no strobes, dsrd_hdng unchanged.
- 300 forced turns -> turn_cnt saturates at FF. Stray mv_cmplt in SETTLE -> ignored.
